flag_cond_unit: RTL and testbench
=================================

FLAG_COND_UNIT -- requirements
Module: flag_cond_unit

Interface
REQ-001 SHALL have parameter BYPASS, default 1, meaning: 1 = a flag write in the same cycle is forwarded to condition evaluation; 0 = evaluation uses only the registered flags.
REQ-002 SHALL have parameter CNTW, default 16, meaning: width of the failed-condition counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 flags_in  input  4  NZCV from subtractor/ALU; [3]=N, [2]=Z, [1]=C, [0]=V.
REQ-007 flags_we  input  1  set-flags instruction commits flags_in this cycle.
REQ-008 cond  input  4  condition field of the instruction being evaluated.
REQ-009 cond_valid  input  1  cond holds a valid instruction this cycle.
REQ-010 stall  input  1  pipeline freeze.
REQ-011 flush  input  1  squash the instruction in the evaluation stage.
REQ-012 flags_q  output  4  architectural NZCV register.
REQ-013 exec_out  output  1  registered condition-pass result.
REQ-014 exec_valid  output  1  exec_out qualifies a valid instruction.
REQ-015 skip_cnt  output  CNTW  saturating count of valid instructions whose condition failed.

Function
REQ-016 Flag register SHALL load flags_in at the clock edge when flags_we=1 and stall=0, and otherwise hold.
REQ-017 Effective flags SHALL be flags_in when BYPASS=1 and flags_we=1, and flags_q in all other cases.
REQ-018 Pass SHALL be computed from effective flags per cond:
- 0 EQ: Z; 1 NE: !Z; 2 CS: C; 3 CC: !C.
- 4 MI: N; 5 PL: !N; 6 VS: V; 7 VC: !V.
- 8 HI: C&!Z; 9 LS: !C|Z; A GE: N==V; B LT: N!=V.
- C GT: !Z&(N==V); D LE: Z|(N!=V); E AL: 1; F: 1 (unconditional).
REQ-019 Latency SHALL be one cycle: exec_out/exec_valid reflect the cond/cond_valid sampled at the previous edge.
REQ-020 When stall=0 and flush=0: exec_valid <= cond_valid; exec_out <= cond_valid & pass.
REQ-021 When stall=1 and flush=0: exec_out, exec_valid, flags_q and skip_cnt SHALL all hold.
REQ-022 When flush=1, regardless of stall: exec_valid <= 0 and exec_out <= 0; skip_cnt is not incremented.
REQ-023 Under flush, the flag write SHALL still follow REQ-016, because the committing instruction is older than the flushed one.
REQ-024 skip_cnt SHALL increment by 1 when cond_valid=1, pass=0, stall=0 and flush=0.
REQ-025 skip_cnt SHALL saturate at all-ones and never wrap to 0.
REQ-026 exec_out SHALL never be 1 while exec_valid=0.
REQ-027 Simultaneous flags_we and cond_valid with BYPASS=1 SHALL evaluate against the incoming flags_in, never the stale flags_q.

Reset
REQ-028 When rst=1 at a clock edge, the next values SHALL be flags_q=4'b0000, exec_out=0, exec_valid=0, skip_cnt=0.
REQ-029 rst SHALL take priority over stall, flush and flags_we.
REQ-030 A cond_valid presented during a cycle with rst=1 SHALL be discarded.
REQ-031 The first evaluation after reset SHALL see flags 0000, so EQ fails and NE passes.

Verification
REQ-032 Reset, then cond=0 (EQ) with cond_valid=1 -> next cycle exec_valid=1, exec_out=0, skip_cnt=1.
REQ-033 flags_we=1 with flags_in=4'b0100 and cond=0 in the same cycle, BYPASS=1 -> exec_out=1. With BYPASS=0 -> exec_out=0, and flags_q=0100 afterwards.
REQ-034 flags_q=4'b1001 (N=1, V=1), cond=A (GE) -> exec_out=1; cond=C (GT) -> exec_out=1; cond=B (LT) -> exec_out=0.
REQ-035 Hold stall=1 for 3 cycles with flags_we=1 and cond_valid=1 -> outputs, flags_q and skip_cnt unchanged. Release stall -> single update.
REQ-036 flush=1 with stall=1 and a failing cond -> exec_valid=0, exec_out=0, skip_cnt unchanged. A concurrent flags_we with stall=0 -> flags_q updated.
REQ-037 CNTW=4, apply 17 consecutive failing valid instructions -> skip_cnt=4'hF and holds. Assert rst mid-sequence -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/flag_cond_unit.sv
// rtl/flag_cond_unit.sv - NZCV flag register with one-cycle condition evaluation and failed-condition counter
module flag_cond_unit #(
    parameter int BYPASS = 1,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      flags_in,
    input  logic            flags_we,
    input  logic [3:0]      cond,
    input  logic            cond_valid,
    input  logic            stall,
    input  logic            flush,
    output logic [3:0]      flags_q,
    output logic            exec_out,
    output logic            exec_valid,
    output logic [CNTW-1:0] skip_cnt
);

    logic [3:0]      flag_reg_q,   flag_reg_d;
    logic            exec_out_q,   exec_out_d;
    logic            exec_valid_q, exec_valid_d;
    logic [CNTW-1:0] skip_cnt_q,   skip_cnt_d;

    logic [3:0] eff_flags;
    logic       n_f, z_f, c_f, v_f;
    logic       pass;
    logic       cnt_sat;

    // A flag write in the same cycle is newer than the register, so forward it when enabled
    assign eff_flags = ((BYPASS != 0) && flags_we) ? flags_in : flag_reg_q;
    assign {n_f, z_f, c_f, v_f} = eff_flags;
    assign cnt_sat = &skip_cnt_q;

    always_comb begin
        pass = 1'b1;
        case (cond)
            4'h0: pass = z_f;
            4'h1: pass = !z_f;
            4'h2: pass = c_f;
            4'h3: pass = !c_f;
            4'h4: pass = n_f;
            4'h5: pass = !n_f;
            4'h6: pass = v_f;
            4'h7: pass = !v_f;
            4'h8: pass = c_f && !z_f;
            4'h9: pass = !c_f || z_f;
            4'hA: pass = (n_f == v_f);
            4'hB: pass = (n_f != v_f);
            4'hC: pass = !z_f && (n_f == v_f);
            4'hD: pass = z_f || (n_f != v_f);
            default: pass = 1'b1;
        endcase
    end

    always_comb begin
        flag_reg_d   = flag_reg_q;
        exec_out_d   = exec_out_q;
        exec_valid_d = exec_valid_q;
        skip_cnt_d   = skip_cnt_q;
        // The committing instruction is older than a flushed one, so flush does not block the write
        if (flags_we && !stall) begin
            flag_reg_d = flags_in;
        end
        if (flush) begin
            exec_valid_d = 1'b0;
            exec_out_d   = 1'b0;
        end else if (!stall) begin
            exec_valid_d = cond_valid;
            exec_out_d   = cond_valid && pass;
            if (cond_valid && !pass && !cnt_sat) begin
                skip_cnt_d = skip_cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_reg_q   <= 4'b0000;
            exec_out_q   <= 1'b0;
            exec_valid_q <= 1'b0;
            skip_cnt_q   <= '0;
        end else begin
            flag_reg_q   <= flag_reg_d;
            exec_out_q   <= exec_out_d;
            exec_valid_q <= exec_valid_d;
            skip_cnt_q   <= skip_cnt_d;
        end
    end

    assign flags_q    = flag_reg_q;
    assign exec_out   = exec_out_q;
    assign exec_valid = exec_valid_q;
    assign skip_cnt   = skip_cnt_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// tb/tb_flag_cond_unit.sv - self-checking bench for flag_cond_unit (default, no-bypass and 4-bit counter instances)
module tb_flag_cond_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] flags_in = 4'h0;
    logic       flags_we = 1'b0;
    logic [3:0] cond = 4'h0;
    logic       cond_valid = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;

    logic [3:0]  d_flags [3];
    logic        d_exec  [3];
    logic        d_valid [3];
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;
    logic [31:0] d_cnt [3];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    flag_cond_unit u0 (
        .clk(clk), .rst(rst), .flags_in(flags_in), .flags_we(flags_we), .cond(cond),
        .cond_valid(cond_valid), .stall(stall), .flush(flush), .flags_q(d_flags[0]),
        .exec_out(d_exec[0]), .exec_valid(d_valid[0]), .skip_cnt(cnt0)
    );
    flag_cond_unit #(.BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .flags_in(flags_in), .flags_we(flags_we), .cond(cond),
        .cond_valid(cond_valid), .stall(stall), .flush(flush), .flags_q(d_flags[1]),
        .exec_out(d_exec[1]), .exec_valid(d_valid[1]), .skip_cnt(cnt1)
    );
    flag_cond_unit #(.CNTW(4)) u2 (
        .clk(clk), .rst(rst), .flags_in(flags_in), .flags_we(flags_we), .cond(cond),
        .cond_valid(cond_valid), .stall(stall), .flush(flush), .flags_q(d_flags[2]),
        .exec_out(d_exec[2]), .exec_valid(d_valid[2]), .skip_cnt(cnt2)
    );

    assign d_cnt[0] = {16'h0, cnt0};
    assign d_cnt[1] = {16'h0, cnt1};
    assign d_cnt[2] = {28'h0, cnt2};

    // Reference model: per-instance architectural state
    int         byp  [3] = '{1, 0, 1};
    int         cmax [3] = '{65535, 65535, 15};
    logic [3:0] m_flags [3];
    logic       m_exec  [3];
    logic       m_valid [3];
    int         m_cnt   [3];

    // Conditions come in complementary pairs; odd codes invert the even predicate, except E/F
    function automatic logic mpass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, b;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: return 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_flags[i] <= 4'h0;
                m_exec[i]  <= 1'b0;
                m_valid[i] <= 1'b0;
                m_cnt[i]   <= 0;
            end else begin
                if (flags_we && !stall) m_flags[i] <= flags_in;
                if (flush) begin
                    m_valid[i] <= 1'b0;
                    m_exec[i]  <= 1'b0;
                end else if (!stall) begin
                    m_valid[i] <= cond_valid;
                    m_exec[i]  <= cond_valid &&
                                  mpass(cond, (byp[i] != 0 && flags_we) ? flags_in : m_flags[i]);
                    if (cond_valid && m_cnt[i] < cmax[i] &&
                        !mpass(cond, (byp[i] != 0 && flags_we) ? flags_in : m_flags[i]))
                        m_cnt[i] <= m_cnt[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d.flags_q", i), {28'h0, d_flags[i]}, {28'h0, m_flags[i]});
                chk($sformatf("u%0d.exec_out", i), {31'h0, d_exec[i]}, {31'h0, m_exec[i]});
                chk($sformatf("u%0d.exec_valid", i), {31'h0, d_valid[i]}, {31'h0, m_valid[i]});
                chk($sformatf("u%0d.skip_cnt", i), d_cnt[i], m_cnt[i]);
                chk($sformatf("u%0d.exec_wo_valid", i), {31'h0, d_exec[i] & ~d_valid[i]}, 32'h0);
            end
        end
    end

    task automatic cyc(input logic r, input logic we, input logic [3:0] fin, input logic [3:0] c,
                       input logic cv, input logic st, input logic fl);
        rst = r; flags_we = we; flags_in = fin; cond = c;
        cond_valid = cv; stall = st; flush = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        cyc(1, 1, 4'hF, 4'h1, 1, 0, 0);
        chk_en = 1'b1;
        chk("rst.flags", {28'h0, d_flags[0]}, 32'h0);
        chk("rst.valid", {31'h0, d_valid[0]}, 32'h0);
        chk("rst.exec", {31'h0, d_exec[0]}, 32'h0);
        chk("rst.cnt", d_cnt[0], 32'h0);

        // First evaluation after reset sees 0000: EQ fails, NE passes
        cyc(0, 0, 4'h0, 4'h0, 1, 0, 0);
        chk("eq0.valid", {31'h0, d_valid[0]}, 32'h1);
        chk("eq0.exec", {31'h0, d_exec[0]}, 32'h0);
        chk("eq0.cnt", d_cnt[0], 32'h1);
        cyc(0, 0, 4'h0, 4'h1, 1, 0, 0);
        chk("ne0.exec", {31'h0, d_exec[0]}, 32'h1);

        // Same-cycle flag write: bypass vs registered
        cyc(0, 1, 4'b0100, 4'h0, 1, 0, 0);
        chk("byp1.exec", {31'h0, d_exec[0]}, 32'h1);
        chk("byp0.exec", {31'h0, d_exec[1]}, 32'h0);
        chk("byp0.flags", {28'h0, d_flags[1]}, 32'h4);
        chk("byp0.cnt", d_cnt[1], 32'h2);

        // N=1,V=1: GE, GT pass; LT fails
        cyc(0, 1, 4'b1001, 4'h0, 0, 0, 0);
        cyc(0, 0, 4'h0, 4'hA, 1, 0, 0);
        chk("ge.exec", {31'h0, d_exec[0]}, 32'h1);
        cyc(0, 0, 4'h0, 4'hC, 1, 0, 0);
        chk("gt.exec", {31'h0, d_exec[0]}, 32'h1);
        cyc(0, 0, 4'h0, 4'hB, 1, 0, 0);
        chk("lt.exec", {31'h0, d_exec[0]}, 32'h0);
        chk("lt.cnt", d_cnt[0], 32'h2);

        // Stall holds everything for three cycles, then a single update
        cyc(0, 0, 4'h0, 4'hA, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 4'b0100, 4'hB, 1, 1, 0);
            chk("stall.exec", {31'h0, d_exec[0]}, 32'h1);
            chk("stall.flags", {28'h0, d_flags[0]}, 32'h9);
            chk("stall.cnt", d_cnt[0], 32'h2);
        end
        cyc(0, 1, 4'b0100, 4'hB, 1, 0, 0);
        chk("unstall.flags", {28'h0, d_flags[0]}, 32'h4);
        chk("unstall.exec", {31'h0, d_exec[0]}, 32'h0);
        chk("unstall.cnt", d_cnt[0], 32'h3);

        // Flush with stall: squashed, counter untouched, flags held
        cyc(0, 1, 4'hF, 4'h1, 1, 1, 1);
        chk("flush_st.valid", {31'h0, d_valid[0]}, 32'h0);
        chk("flush_st.cnt", d_cnt[0], 32'h3);
        chk("flush_st.flags", {28'h0, d_flags[0]}, 32'h4);
        cyc(0, 1, 4'b0010, 4'h1, 1, 0, 1);
        chk("flush.flags", {28'h0, d_flags[0]}, 32'h2);
        chk("flush.valid", {31'h0, d_valid[0]}, 32'h0);

        // Sweep every condition against several flag patterns
        for (int p = 0; p < 5; p++) begin
            logic [3:0] fv;
            fv = (p == 0) ? 4'h0 : (p == 1) ? 4'hF : (p == 2) ? 4'h5 : (p == 3) ? 4'hA : 4'h6;
            for (int c = 0; c < 16; c++) begin
                cyc(0, (c == 0), fv, 4'(c), 1, 0, 0);
            end
        end
        cyc(0, 1, 4'h0, 4'hF, 1, 0, 0);
        chk("al.exec", {31'h0, d_exec[0]}, 32'h1);

        // Saturation of the 4-bit counter
        for (int k = 0; k < 17; k++) cyc(0, 1, 4'h0, 4'h0, 1, 0, 0);
        chk("sat.cnt", d_cnt[2], 32'hF);
        cyc(0, 0, 4'h0, 4'h0, 1, 0, 0);
        chk("sat.hold", d_cnt[2], 32'hF);
        cyc(1, 1, 4'hF, 4'h0, 1, 1, 1);
        chk("midrst.cnt", d_cnt[2], 32'h0);
        chk("midrst.valid", {31'h0, d_valid[2]}, 32'h0);
        chk("midrst.flags", {28'h0, d_flags[2]}, 32'h0);
        cyc(0, 0, 4'h0, 4'h0, 1, 0, 0);
        chk("postrst.cnt", d_cnt[2], 32'h1);
        cyc(0, 0, 4'h0, 4'h0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
